// File: rtl/tdm_demux_1x4.sv
// Registered 1-to-4 TDM demultiplexer: round-robin routes a serial sample lane
// into four channel holding registers, tracking frame alignment via start-of-frame.
module tdm_demux_1x4 #(
    parameter int WIDTH = 8,
    parameter int ERRW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sof,
    output logic [4*WIDTH-1:0] ch_data,
    output logic [3:0]         ch_valid,
    output logic               frame_valid,
    output logic               locked,
    output logic               sync_err,
    output logic [ERRW-1:0]    err_count
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0] state, state_n;
    logic [1:0] cnt, cnt_n;
    logic       frame_ok, frame_ok_n;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic       err_ev;
    logic       fv_n;

    // Handshake: in_valid alone qualifies in_data/in_sof; there is no ready,
    // every valid cycle is consumed and idle cycles leave all state untouched.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        frame_ok_n = frame_ok;
        wr_en      = 1'b0;
        wr_idx     = cnt;
        err_ev     = 1'b0;
        fv_n       = 1'b0;
        if (in_valid) begin
            if (state == HUNT) begin
                if (in_sof) begin
                    wr_en      = 1'b1;
                    wr_idx     = 2'd0;
                    cnt_n      = 2'd1;
                    frame_ok_n = 1'b1;
                    state_n    = LOCKED;
                end
            end else if (in_sof) begin
                // An early SOF abandons the partial frame but resyncs at once.
                err_ev     = (cnt != 2'd0);
                wr_en      = 1'b1;
                wr_idx     = 2'd0;
                cnt_n      = 2'd1;
                frame_ok_n = 1'b1;
            end else if (cnt == 2'd0) begin
                err_ev     = 1'b1;
                frame_ok_n = 1'b0;
                state_n    = HUNT;
            end else begin
                wr_en  = 1'b1;
                wr_idx = cnt;
                cnt_n  = cnt + 2'd1;
                fv_n   = frame_ok && (cnt == 2'd3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            cnt         <= 2'd0;
            frame_ok    <= 1'b0;
            ch_data     <= '0;
            ch_valid    <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            frame_ok    <= frame_ok_n;
            ch_valid    <= wr_en ? (4'b0001 << wr_idx) : 4'b0000;
            frame_valid <= fv_n;
            sync_err    <= err_ev;
            for (int i = 0; i < 4; i++) begin
                if (wr_en && (wr_idx == 2'(i)))
                    ch_data[i*WIDTH +: WIDTH] <= in_data;
            end
            if (err_ev && (err_count != {ERRW{1'b1}}))
                err_count <= err_count + 1'b1;
        end
    end

    assign locked = (state == LOCKED);

endmodule
